// File: rtl/cv32e40x_flush_sequencer.sv
// Flush handshake sequencer for the controller.
// Fans a single flush start out to NUM_CH downstream agents. Agents are
// requested either all at once or one at a time, lowest index first.
// Requests are held off while the LSU is busy, and each request phase can be
// bounded by a cycle timeout. done_o pulses for one cycle when the flush ends.
// ack_mask_o then shows which agents acknowledged.

module cv32e40x_flush_sequencer #(
    parameter int unsigned NUM_CH     = 2,
    parameter bit          SEQUENTIAL = 1'b0,
    parameter int unsigned TIMEOUT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [NUM_CH-1:0]    ch_en_i,
    input  logic                 lsu_busy_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic [NUM_CH-1:0]    flush_req_o,
    input  logic [NUM_CH-1:0]    flush_ack_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [NUM_CH-1:0]    ack_mask_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LSU,
        REQ,
        DONE
    } state_e;

    state_e               state_q;
    logic [NUM_CH-1:0]    pend_q;
    logic [NUM_CH-1:0]    req_q;
    logic [NUM_CH-1:0]    ack_mask_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] tmo_lim_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 tmo_q;

    logic [NUM_CH-1:0]    ack_hit;
    logic [NUM_CH-1:0]    pend_nxt;
    logic                 expire;

    // Isolates the lowest set bit (two's complement trick).
    function automatic logic [NUM_CH-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        return v & (~v + NUM_CH'(1));
    endfunction

    // Request vector for a given set of pending channels.
    function automatic logic [NUM_CH-1:0] req_for(input logic [NUM_CH-1:0] v);
        return SEQUENTIAL ? lowest_set(v) : v;
    endfunction

    // An ack counts only on a channel that is currently being requested.
    assign ack_hit  = flush_ack_i & req_q;
    assign pend_nxt = pend_q & ~ack_hit;

    // The phase budget is exhausted on this cycle (the limit is sampled at start).
    assign expire = (tmo_lim_q != '0) && (cnt_q == tmo_lim_q - TIMEOUT_W'(1));

    // Sequencer FSM; every output is driven straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            req_q      <= '0;
            ack_mask_q <= '0;
            cnt_q      <= '0;
            tmo_lim_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge state. The default below turns done_q into a pulse.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        pend_q     <= ch_en_i;
                        ack_mask_q <= '0;
                        tmo_lim_q  <= timeout_i;
                        cnt_q      <= '0;
                        tmo_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        if (ch_en_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (lsu_busy_i) begin
                            state_q <= WAIT_LSU;
                        end else begin
                            state_q <= REQ;
                            req_q   <= req_for(ch_en_i);
                        end
                    end
                end

                WAIT_LSU: begin
                    if (!lsu_busy_i) begin
                        state_q <= REQ;
                        req_q   <= req_for(pend_q);
                        cnt_q   <= '0;
                    end
                end

                REQ: begin
                    pend_q     <= pend_nxt;
                    ack_mask_q <= ack_mask_q | ack_hit;
                    if (pend_nxt == '0) begin
                        // Last ack wins even on the expiry cycle.
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        req_q   <= '0;
                    end else if (expire) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        tmo_q   <= 1'b1;
                        pend_q  <= '0;
                        req_q   <= '0;
                    end else begin
                        req_q <= req_for(pend_nxt);
                        if (SEQUENTIAL && (ack_hit != '0)) begin
                            cnt_q <= '0;
                        end else if (!(&cnt_q)) begin
                            cnt_q <= cnt_q + TIMEOUT_W'(1);
                        end
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    tmo_q   <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    req_q   <= '0;
                end
            endcase
        end
    end

    assign flush_req_o = req_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign timeout_o   = tmo_q;
    assign ack_mask_o  = ack_mask_q;

    // An agent must never acknowledge a flush it was not asked for.
    a_ack_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
        ((flush_ack_i & ~req_q) == '0));

    // A start while busy is ignored: it must not clear the acks collected so far.
    a_start_busy_ignored: assert property (@(posedge clk) disable iff (!rst_n)
        (start_i && busy_q) |=> ((ack_mask_q & $past(ack_mask_q)) == $past(ack_mask_q)));

endmodule

// File: tb/tb_cv32e40x_flush_sequencer.sv
// Bench for cv32e40x_flush_sequencer.
// Drives one parallel and one sequential instance. Each test task pushes the
// completion it expects (ack mask, timeout flag, done cycle) into a scoreboard
// queue. Every falling edge pops and compares one entry whenever done_o pulses.

module tb_cv32e40x_flush_sequencer;

    localparam int N  = 2;
    localparam int TW = 8;

    typedef struct {
        logic [N-1:0] mask;
        logic         tmo;
        int           cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          p_start, p_lsu, p_busy, p_done, p_tmo;
    logic [N-1:0]  p_ch_en, p_ack, p_req, p_mask;
    logic [TW-1:0] p_timeout;

    logic          s_start, s_lsu, s_busy, s_done, s_tmo;
    logic [N-1:0]  s_ch_en, s_ack, s_req, s_mask;
    logic [TW-1:0] s_timeout;

    exp_t par_q[$];
    exp_t seq_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    // Count rising edges; tests convert this count into expected done cycles.
    always @(posedge clk) cyc <= cyc + 1;

    cv32e40x_flush_sequencer #(.NUM_CH(N), .SEQUENTIAL(1'b0), .TIMEOUT_W(TW)) u_par (
        .clk(clk), .rst_n(rst_n), .start_i(p_start), .ch_en_i(p_ch_en),
        .lsu_busy_i(p_lsu), .timeout_i(p_timeout), .flush_req_o(p_req),
        .flush_ack_i(p_ack), .busy_o(p_busy), .done_o(p_done),
        .timeout_o(p_tmo), .ack_mask_o(p_mask)
    );

    cv32e40x_flush_sequencer #(.NUM_CH(N), .SEQUENTIAL(1'b1), .TIMEOUT_W(TW)) u_seq (
        .clk(clk), .rst_n(rst_n), .start_i(s_start), .ch_en_i(s_ch_en),
        .lsu_busy_i(s_lsu), .timeout_i(s_timeout), .flush_req_o(s_req),
        .flush_ack_i(s_ack), .busy_o(s_busy), .done_o(s_done),
        .timeout_o(s_tmo), .ack_mask_o(s_mask)
    );

    // Pop and compare one expected completion when an instance pulses done_o.
    task automatic sb_check_one(input bit seq);
        logic         done, tmo;
        logic [N-1:0] mask;
        string        nm;
        int           depth;
        exp_t         e;
        done  = seq ? s_done : p_done;
        tmo   = seq ? s_tmo  : p_tmo;
        mask  = seq ? s_mask : p_mask;
        nm    = seq ? "seq"  : "par";
        depth = seq ? seq_q.size() : par_q.size();
        if (done === 1'b1) begin
            checks++;
            if (depth == 0) begin
                errors++;
                $display("FAIL %s_done_unexpected: done_o=1 at cycle %0d, required no completion", nm, cyc);
            end else begin
                if (seq) e = seq_q.pop_front();
                else     e = par_q.pop_front();
                checks++;
                if (mask !== e.mask) begin
                    errors++;
                    $display("FAIL %s_ack_mask: ack_mask_o=%b, required %b", nm, mask, e.mask);
                end
                checks++;
                if (tmo !== e.tmo) begin
                    errors++;
                    $display("FAIL %s_timeout_flag: timeout_o=%b, required %b", nm, tmo, e.tmo);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL %s_done_cycle: done_o at cycle %0d, required %0d", nm, cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sb_check_one(1'b0);
        sb_check_one(1'b1);
    endtask

    // Bounded wait for every expected completion to have been seen.
    task automatic drain();
        int n;
        n = 0;
        while ((par_q.size() != 0 || seq_q.size() != 0) && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (par_q.size() != 0 || seq_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d par / %0d seq completions missing after %0d cycles, required 0",
                     par_q.size(), seq_q.size(), n);
            par_q.delete();
            seq_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        p_start = 1'b0; p_lsu = 1'b0; p_ch_en = '0; p_ack = '0; p_timeout = '0;
        s_start = 1'b0; s_lsu = 1'b0; s_ch_en = '0; s_ack = '0; s_timeout = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({p_req, p_busy, p_done, p_tmo, p_mask} !== '0) begin
            errors++;
            $display("FAIL par_reset_outputs: %b, required all zero", {p_req, p_busy, p_done, p_tmo, p_mask});
        end
        checks++;
        if ({s_req, s_busy, s_done, s_tmo, s_mask} !== '0) begin
            errors++;
            $display("FAIL seq_reset_outputs: %b, required all zero", {s_req, s_busy, s_done, s_tmo, s_mask});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({p_busy, s_busy} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_release: busy_o par/seq=%b, required 00", {p_busy, s_busy});
        end
    endtask

    task automatic test_parallel();
        int c0;
        c0 = cyc;
        p_ch_en = 2'b11; p_start = 1'b1;
        par_q.push_back(exp_t'{mask: 2'b11, tmo: 1'b0, cyc: c0 + 2});
        step();
        p_start = 1'b0;
        checks++;
        if (p_req !== 2'b11) begin
            errors++; $display("FAIL par_req_t1: flush_req_o=%b, required 11", p_req);
        end
        checks++;
        if (p_busy !== 1'b1) begin
            errors++; $display("FAIL par_busy_t1: busy_o=%b, required 1", p_busy);
        end
        p_ack = 2'b11;
        step();
        p_ack = 2'b00;
        checks++;
        if (p_req !== 2'b00) begin
            errors++; $display("FAIL par_req_t2: flush_req_o=%b, required 00", p_req);
        end
        step();
        checks++;
        if (p_busy !== 1'b0) begin
            errors++; $display("FAIL par_busy_t3: busy_o=%b, required 0", p_busy);
        end
    endtask

    // Start again on the first IDLE cycle after a flush.
    task automatic test_back_to_back();
        int c0;
        c0 = cyc;
        p_ch_en = 2'b01; p_start = 1'b1;
        par_q.push_back(exp_t'{mask: 2'b01, tmo: 1'b0, cyc: c0 + 2});
        step();
        p_start = 1'b0;
        checks++;
        if (p_req !== 2'b01) begin
            errors++; $display("FAIL b2b_req_t1: flush_req_o=%b, required 01", p_req);
        end
        p_ack = 2'b01;
        step();
        p_ack = 2'b00;
        step();
        checks++;
        if (p_busy !== 1'b0) begin
            errors++; $display("FAIL b2b_busy_t3: busy_o=%b, required 0", p_busy);
        end
    endtask

    task automatic test_staggered();
        int c0;
        c0 = cyc;
        p_ch_en = 2'b11; p_start = 1'b1;
        par_q.push_back(exp_t'{mask: 2'b11, tmo: 1'b0, cyc: c0 + 4});
        step();
        p_start = 1'b0;
        checks++;
        if (p_req !== 2'b11) begin
            errors++; $display("FAIL stag_req_t1: flush_req_o=%b, required 11", p_req);
        end
        p_ack = 2'b10;
        step();
        p_ack = 2'b00;
        checks++;
        if (p_req !== 2'b01) begin
            errors++; $display("FAIL stag_req_t2: flush_req_o=%b, required 01", p_req);
        end
        step();
        checks++;
        if (p_req !== 2'b01) begin
            errors++; $display("FAIL stag_req_t3: flush_req_o=%b, required 01", p_req);
        end
        p_ack = 2'b01;
        step();
        p_ack = 2'b00;
        checks++;
        if (p_req !== 2'b00) begin
            errors++; $display("FAIL stag_req_t4: flush_req_o=%b, required 00", p_req);
        end
        step();
    endtask

    task automatic test_lsu_gate();
        int c0;
        c0 = cyc;
        p_ch_en = 2'b11; p_lsu = 1'b1; p_start = 1'b1;
        par_q.push_back(exp_t'{mask: 2'b11, tmo: 1'b0, cyc: c0 + 8});
        step();
        p_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({p_req, p_busy} !== 3'b001) begin
                errors++;
                $display("FAIL lsu_hold_t%0d: flush_req_o=%b busy_o=%b, required 00 and 1", i, p_req, p_busy);
            end
            step();
        end
        p_lsu = 1'b0;
        checks++;
        if (p_req !== 2'b00) begin
            errors++; $display("FAIL lsu_release_t5: flush_req_o=%b, required 00", p_req);
        end
        step();
        checks++;
        if (p_req !== 2'b11) begin
            errors++; $display("FAIL lsu_req_t6: flush_req_o=%b, required 11", p_req);
        end
        // Input changes inside REQ must not disturb the flush in flight.
        p_ch_en = 2'b00; p_lsu = 1'b1; p_timeout = 8'd1;
        p_ack = 2'b01;
        step();
        p_ack = 2'b00;
        checks++;
        if (p_req !== 2'b10) begin
            errors++; $display("FAIL lsu_req_t7: flush_req_o=%b, required 10", p_req);
        end
        p_ack = 2'b10;
        step();
        p_ack = 2'b00; p_lsu = 1'b0; p_timeout = '0;
        step();
    endtask

    task automatic test_timeout();
        int c0;
        c0 = cyc;
        p_ch_en = 2'b11; p_timeout = 8'd4; p_start = 1'b1;
        par_q.push_back(exp_t'{mask: 2'b01, tmo: 1'b1, cyc: c0 + 5});
        step();
        p_start = 1'b0; p_timeout = '0;
        checks++;
        if (p_req !== 2'b11) begin
            errors++; $display("FAIL tmo_req_t1: flush_req_o=%b, required 11", p_req);
        end
        p_ack = 2'b01;
        step();
        p_ack = 2'b00;
        for (int i = 2; i <= 4; i++) begin
            checks++;
            if (p_req !== 2'b10) begin
                errors++; $display("FAIL tmo_req_t%0d: flush_req_o=%b, required 10", i, p_req);
            end
            step();
        end
        checks++;
        if (p_req !== 2'b00) begin
            errors++; $display("FAIL tmo_req_t5: flush_req_o=%b, required 00", p_req);
        end
        step();
        checks++;
        if ({p_busy, p_tmo} !== 2'b00) begin
            errors++; $display("FAIL tmo_after_t6: busy_o/timeout_o=%b, required 00", {p_busy, p_tmo});
        end
    endtask

    // An ack on the expiry cycle is recorded; it suppresses the timeout only
    // when it was the last pending channel.
    task automatic test_ack_on_expiry();
        int c0;
        for (int k = 0; k < 2; k++) begin
            c0 = cyc;
            p_ch_en = (k == 0) ? 2'b01 : 2'b11;
            p_timeout = 8'd2; p_start = 1'b1;
            par_q.push_back(exp_t'{mask: 2'b01, tmo: (k == 1), cyc: c0 + 3});
            step();
            p_start = 1'b0;
            step();
            p_ack = 2'b01;
            step();
            p_ack = 2'b00;
            checks++;
            if (p_req !== 2'b00) begin
                errors++; $display("FAIL expiry%0d_req_t3: flush_req_o=%b, required 00", k, p_req);
            end
            step();
        end
        p_timeout = '0;
    endtask

    task automatic test_sequential();
        int           c0;
        logic [N-1:0] exp_req;
        c0 = cyc;
        s_ch_en = 2'b11; s_start = 1'b1;
        seq_q.push_back(exp_t'{mask: 2'b11, tmo: 1'b0, cyc: c0 + 7});
        step();
        s_start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            exp_req = (i <= 3) ? 2'b01 : 2'b10;
            checks++;
            if (s_req !== exp_req) begin
                errors++; $display("FAIL seq_req_t%0d: flush_req_o=%b, required %b", i, s_req, exp_req);
            end
            s_ack = (i == 3) ? 2'b01 : ((i == 6) ? 2'b10 : 2'b00);
            step();
        end
        s_ack = 2'b00;
        checks++;
        if (s_req !== 2'b00) begin
            errors++; $display("FAIL seq_req_t7: flush_req_o=%b, required 00", s_req);
        end
        step();
    endtask

    // Each sequential phase gets a fresh timeout budget.
    task automatic test_seq_timeout();
        int           c0;
        logic [N-1:0] exp_req;
        c0 = cyc;
        s_ch_en = 2'b11; s_timeout = 8'd3; s_start = 1'b1;
        seq_q.push_back(exp_t'{mask: 2'b01, tmo: 1'b1, cyc: c0 + 6});
        step();
        s_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            exp_req = (i <= 2) ? 2'b01 : 2'b10;
            checks++;
            if (s_req !== exp_req) begin
                errors++; $display("FAIL seqtmo_req_t%0d: flush_req_o=%b, required %b", i, s_req, exp_req);
            end
            s_ack = (i == 2) ? 2'b01 : 2'b00;
            step();
        end
        s_ack = 2'b00; s_timeout = '0;
        checks++;
        if (s_req !== 2'b00) begin
            errors++; $display("FAIL seqtmo_req_t6: flush_req_o=%b, required 00", s_req);
        end
        step();
    endtask

    task automatic test_empty_and_busy_start();
        int c0;
        c0 = cyc;
        p_ch_en = 2'b00; p_start = 1'b1;
        par_q.push_back(exp_t'{mask: 2'b00, tmo: 1'b0, cyc: c0 + 1});
        step();
        p_start = 1'b0;
        checks++;
        if (p_req !== 2'b00) begin
            errors++; $display("FAIL empty_req_t1: flush_req_o=%b, required 00", p_req);
        end
        step();
        checks++;
        if (p_busy !== 1'b0) begin
            errors++; $display("FAIL empty_busy_t2: busy_o=%b, required 0", p_busy);
        end
        c0 = cyc;
        p_ch_en = 2'b01; p_start = 1'b1;
        par_q.push_back(exp_t'{mask: 2'b01, tmo: 1'b0, cyc: c0 + 3});
        step();
        checks++;
        if (p_req !== 2'b01) begin
            errors++; $display("FAIL busy_start_req_t1: flush_req_o=%b, required 01", p_req);
        end
        p_ch_en = 2'b10;
        step();
        p_start = 1'b0; p_ch_en = 2'b00;
        checks++;
        if (p_req !== 2'b01) begin
            errors++; $display("FAIL busy_start_req_t2: flush_req_o=%b, required 01", p_req);
        end
        p_ack = 2'b01;
        step();
        p_ack = 2'b00;
        step();
        checks++;
        if ({p_req, p_busy} !== 3'b000) begin
            errors++; $display("FAIL busy_start_idle_t4: flush_req_o=%b busy_o=%b, required 00 and 0", p_req, p_busy);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        p_ch_en = 2'b11; p_start = 1'b1;
        step();
        p_start = 1'b0;
        p_ack = 2'b01;
        step();
        p_ack = 2'b00;
        checks++;
        if ({p_req, p_mask} !== 4'b1001) begin
            errors++; $display("FAIL mid_before_reset: flush_req_o=%b ack_mask_o=%b, required 10 and 01", p_req, p_mask);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({p_req, p_busy, p_done, p_tmo, p_mask} !== '0) begin
            errors++;
            $display("FAIL mid_async_reset: %b, required all zero", {p_req, p_busy, p_done, p_tmo, p_mask});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        c0 = cyc;
        p_ch_en = 2'b10; p_start = 1'b1;
        par_q.push_back(exp_t'{mask: 2'b10, tmo: 1'b0, cyc: c0 + 2});
        step();
        p_start = 1'b0;
        checks++;
        if (p_req !== 2'b10) begin
            errors++; $display("FAIL post_reset_req_t1: flush_req_o=%b, required 10", p_req);
        end
        p_ack = 2'b10;
        step();
        p_ack = 2'b00;
        step();
    endtask

    initial begin
        test_reset();
        test_parallel();
        test_back_to_back();
        test_staggered();
        test_lsu_gate();
        test_timeout();
        test_ack_on_expiry();
        test_sequential();
        test_seq_timeout();
        test_empty_and_busy_start();
        test_reset_mid();
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
